// File: rtl/hazard_fwd_unit_if.sv
// Decoder <-> hazard/forwarding unit bundle: ID-stage operands, downstream
// stage destinations, branch resolution, and the resulting pipeline controls.
interface hazard_fwd_unit_if #(
    parameter int AW   = 5,
    parameter int NSTG = 2
);
    localparam int SW = $clog2(NSTG + 2);

    // ID-stage instruction description
    logic                 id_valid;
    logic [AW-1:0]        id_rs1;
    logic [AW-1:0]        id_rs2;
    logic                 id_rs1_used;
    logic                 id_rs2_used;
    logic                 id_shift;
    logic                 id_aluimm;
    logic                 id_is_branch;
    logic                 id_is_jump;

    // Downstream stages, index 0 = EXE (youngest)
    logic [NSTG*AW-1:0]   stg_rd;
    logic [NSTG-1:0]      stg_wreg;
    logic [NSTG-1:0]      stg_is_load;

    // Branch resolution from the EXE side
    logic                 br_resolve;
    logic                 br_taken;

    // Pipeline controls
    logic                 stall;
    logic                 discard;
    logic                 flush;
    logic [SW-1:0]        alu_a_sel;
    logic [SW-1:0]        alu_b_sel;
    logic [1:0]           pcsource;
    logic                 proto_err;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_shift, id_aluimm, id_is_branch, id_is_jump,
               stg_rd, stg_wreg, stg_is_load, br_resolve, br_taken,
        input  stall, discard, flush, alu_a_sel, alu_b_sel, pcsource, proto_err
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_shift, id_aluimm, id_is_branch, id_is_jump,
               stg_rd, stg_wreg, stg_is_load, br_resolve, br_taken,
        output stall, discard, flush, alu_a_sel, alu_b_sel, pcsource, proto_err
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// ID-stage hazard controller: operand forwarding from NSTG downstream stages,
// load-use stall, and a registered branch/jump FSM that owns stall, squash
// and PC source. A sticky flag records branch resolutions nobody was waiting for.
module hazard_fwd_unit #(
    parameter int AW          = 5,
    parameter int NSTG        = 2,
    parameter int LOAD_LAT    = 1,
    parameter int BR_PENALTY  = 2,
    parameter int JMP_PENALTY = 1
) (
    input  logic              clk,
    input  logic              rst,
    hazard_fwd_unit_if.slave  bus
);
    localparam int SW = $clog2(NSTG + 2);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BR_WAIT = 2'd1,
        ST_SQUASH  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic          proto_err_q;

    logic [SW-1:0] a_fwd_sel, b_fwd_sel;
    logic          a_load, b_load;
    logic          hz, issue;

    logic          stall, discard, flush;
    logic [SW-1:0] alu_a_sel, alu_b_sel;
    logic [1:0]    pcsource;

    // Forwarding match: scan oldest to youngest so the youngest match overwrites.
    always_comb begin
        // NOTE: every comb output gets a default first, otherwise a path that
        // skips the assignment infers a latch.
        a_fwd_sel = '0;
        b_fwd_sel = '0;
        a_load    = 1'b0;
        b_load    = 1'b0;
        for (int k = NSTG - 1; k >= 0; k--) begin
            if (bus.id_rs1_used && bus.stg_wreg[k] && (bus.id_rs1 != '0) &&
                (bus.stg_rd[k*AW +: AW] == bus.id_rs1)) begin
                a_fwd_sel = SW'(k + 2);
                a_load    = bus.stg_is_load[k] && (k < LOAD_LAT);
            end
            if (bus.id_rs2_used && bus.stg_wreg[k] && (bus.id_rs2 != '0) &&
                (bus.stg_rd[k*AW +: AW] == bus.id_rs2)) begin
                b_fwd_sel = SW'(k + 2);
                b_load    = bus.stg_is_load[k] && (k < LOAD_LAT);
            end
        end
    end

    assign hz    = a_load | b_load;
    assign issue = bus.id_valid & ~hz;

    // State register, squash counter and sticky protocol-error flag.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (rst) begin
            state       <= ST_RUN;
            cnt         <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (bus.br_resolve && (state != ST_BR_WAIT))
                proto_err_q <= 1'b1;
        end
    end

    // Next-state logic; a branch in ID takes priority over a jump.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            ST_RUN: begin
                if (issue && bus.id_is_branch) begin
                    state_nxt = ST_BR_WAIT;
                end else if (issue && bus.id_is_jump && (JMP_PENALTY != 0)) begin
                    state_nxt = ST_SQUASH;
                    cnt_nxt   = 4'(JMP_PENALTY);
                end
            end
            ST_BR_WAIT: begin
                if (bus.br_resolve && bus.br_taken && (BR_PENALTY != 0)) begin
                    state_nxt = ST_SQUASH;
                    cnt_nxt   = 4'(BR_PENALTY);
                end else if (bus.br_resolve) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_SQUASH: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1)
                    state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode; everything is held at zero while reset is asserted.
    always_comb begin
        stall     = 1'b0;
        flush     = 1'b0;
        discard   = 1'b0;
        pcsource  = 2'b00;
        alu_a_sel = '0;
        alu_b_sel = '0;
        if (!rst) begin
            alu_a_sel = bus.id_shift  ? SW'(1) : a_fwd_sel;
            alu_b_sel = bus.id_aluimm ? SW'(1) : b_fwd_sel;
            unique case (state)
                ST_RUN: begin
                    stall = hz;
                    if (issue && bus.id_is_jump && !bus.id_is_branch)
                        pcsource = 2'b10;
                end
                ST_BR_WAIT: begin
                    stall = 1'b1;
                    if (bus.br_resolve && bus.br_taken)
                        pcsource = 2'b01;
                end
                ST_SQUASH: begin
                    flush = 1'b1;
                end
                default: ;
            endcase
            discard = stall | flush | ~bus.id_valid;
        end
    end

    assign bus.stall     = stall;
    assign bus.discard   = discard;
    assign bus.flush     = flush;
    assign bus.alu_a_sel = alu_a_sel;
    assign bus.alu_b_sel = alu_b_sel;
    assign bus.pcsource  = pcsource;
    assign bus.proto_err = proto_err_q;
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: NSTG=3, LOAD_LAT=1, BR_PENALTY=2, JMP_PENALTY=1.
module tb_hazard_fwd_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    hazard_fwd_unit_if #(.AW(5), .NSTG(3)) bus ();

    hazard_fwd_unit #(
        .AW(5), .NSTG(3), .LOAD_LAT(1), .BR_PENALTY(2), .JMP_PENALTY(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_valid     = 1'b0;
        bus.id_rs1       = '0;
        bus.id_rs2       = '0;
        bus.id_rs1_used  = 1'b0;
        bus.id_rs2_used  = 1'b0;
        bus.id_shift     = 1'b0;
        bus.id_aluimm    = 1'b0;
        bus.id_is_branch = 1'b0;
        bus.id_is_jump   = 1'b0;
        bus.stg_rd       = '0;
        bus.stg_wreg     = '0;
        bus.stg_is_load  = '0;
        bus.br_resolve   = 1'b0;
        bus.br_taken     = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.id_shift   = 1'b1;
        bus.id_aluimm  = 1'b1;
        bus.br_resolve = 1'b1;
        #2;
        n_tests++;
        if ({bus.stall, bus.discard, bus.flush, bus.pcsource, bus.proto_err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: stall/discard/flush/pcsource/proto_err got %b expected 000000",
                     {bus.stall, bus.discard, bus.flush, bus.pcsource, bus.proto_err});
        end
        n_tests++;
        if (bus.alu_a_sel !== 3'd0 || bus.alu_b_sel !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_sel: a=%0d b=%0d expected 0 0", bus.alu_a_sel, bus.alu_b_sel);
        end
        tick();
        tick();
        n_tests++;
        if (bus.proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_proto: proto_err got %b expected 0", bus.proto_err);
        end
        clear_inputs();
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.discard !== 1'b1 || bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_discard: discard=%b stall=%b expected 1 0", bus.discard, bus.stall);
        end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        bus.id_valid    = 1'b1;
        bus.id_rs1      = 5'd5;
        bus.id_rs1_used = 1'b1;
        bus.stg_rd      = {5'd7, 5'd5, 5'd5};
        bus.stg_wreg    = 3'b111;
        #1;
        n_tests++;
        if (bus.alu_a_sel !== 3'd2 || bus.discard !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_youngest: alu_a_sel=%0d discard=%b expected 2 0", bus.alu_a_sel, bus.discard);
        end
        bus.stg_wreg = 3'b110;
        #1;
        n_tests++;
        if (bus.alu_a_sel !== 3'd3) begin
            n_fail++;
            $display("FAIL fwd_stage1: alu_a_sel got %0d expected 3", bus.alu_a_sel);
        end
        bus.id_rs1_used = 1'b0;
        #1;
        n_tests++;
        if (bus.alu_a_sel !== 3'd0) begin
            n_fail++;
            $display("FAIL fwd_unused: alu_a_sel got %0d expected 0", bus.alu_a_sel);
        end
        bus.id_rs1_used = 1'b1;
        bus.id_shift    = 1'b1;
        #1;
        n_tests++;
        if (bus.alu_a_sel !== 3'd1) begin
            n_fail++;
            $display("FAIL fwd_shift: alu_a_sel got %0d expected 1", bus.alu_a_sel);
        end
        bus.id_shift    = 1'b0;
        bus.id_rs2      = 5'd7;
        bus.id_rs2_used = 1'b1;
        bus.stg_wreg    = 3'b111;
        #1;
        n_tests++;
        if (bus.alu_b_sel !== 3'd4 || bus.alu_a_sel !== 3'd2) begin
            n_fail++;
            $display("FAIL fwd_stage2_b: a=%0d b=%0d expected 2 4", bus.alu_a_sel, bus.alu_b_sel);
        end
    endtask

    task automatic test_r0_guard();
        clear_inputs();
        bus.id_valid    = 1'b1;
        bus.id_rs2      = 5'd0;
        bus.id_rs2_used = 1'b1;
        bus.stg_rd      = {5'd3, 5'd2, 5'd0};
        bus.stg_wreg    = 3'b001;
        #1;
        n_tests++;
        if (bus.alu_b_sel !== 3'd0) begin
            n_fail++;
            $display("FAIL r0_guard: alu_b_sel got %0d expected 0", bus.alu_b_sel);
        end
        bus.id_aluimm = 1'b1;
        #1;
        n_tests++;
        if (bus.alu_b_sel !== 3'd1) begin
            n_fail++;
            $display("FAIL aluimm: alu_b_sel got %0d expected 1", bus.alu_b_sel);
        end
    endtask

    task automatic test_load_use();
        clear_inputs();
        bus.id_valid    = 1'b1;
        bus.id_rs1      = 5'd5;
        bus.id_rs1_used = 1'b1;
        bus.stg_rd      = {5'd0, 5'd0, 5'd5};
        bus.stg_wreg    = 3'b001;
        bus.stg_is_load = 3'b001;
        #1;
        n_tests++;
        if (bus.stall !== 1'b1 || bus.discard !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_stall: stall=%b discard=%b expected 1 1", bus.stall, bus.discard);
        end
        tick();
        bus.stg_rd      = {5'd0, 5'd5, 5'd9};
        bus.stg_wreg    = 3'b011;
        bus.stg_is_load = 3'b010;
        #1;
        n_tests++;
        if (bus.stall !== 1'b0 || bus.alu_a_sel !== 3'd3 || bus.discard !== 1'b0) begin
            n_fail++;
            $display("FAIL load_stage1: stall=%b alu_a_sel=%0d discard=%b expected 0 3 0",
                     bus.stall, bus.alu_a_sel, bus.discard);
        end
        bus.id_rs2      = 5'd9;
        bus.id_rs2_used = 1'b1;
        bus.stg_is_load = 3'b011;
        #1;
        n_tests++;
        if (bus.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL load_use_rs2: stall got %b expected 1", bus.stall);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_branch();
        clear_inputs();
        bus.id_valid     = 1'b1;
        bus.id_is_branch = 1'b1;
        #1;
        n_tests++;
        if (bus.stall !== 1'b0 || bus.pcsource !== 2'b00) begin
            n_fail++;
            $display("FAIL br_issue: stall=%b pcsource=%b expected 0 00", bus.stall, bus.pcsource);
        end
        tick();
        #1;
        n_tests++;
        if (bus.stall !== 1'b1 || bus.discard !== 1'b1 || bus.flush !== 1'b0) begin
            n_fail++;
            $display("FAIL br_wait: stall=%b discard=%b flush=%b expected 1 1 0",
                     bus.stall, bus.discard, bus.flush);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if (bus.stall !== 1'b1 || bus.pcsource !== 2'b00) begin
                n_fail++;
                $display("FAIL br_wait_hold: cycle %0d stall=%b pcsource=%b expected 1 00",
                         i, bus.stall, bus.pcsource);
            end
        end
        tick();
        bus.br_resolve = 1'b1;
        bus.br_taken   = 1'b1;
        #1;
        n_tests++;
        if (bus.pcsource !== 2'b01 || bus.stall !== 1'b1 || bus.flush !== 1'b0) begin
            n_fail++;
            $display("FAIL br_taken: pcsource=%b stall=%b flush=%b expected 01 1 0",
                     bus.pcsource, bus.stall, bus.flush);
        end
        tick();
        clear_inputs();
        #1;
        n_tests++;
        if (bus.flush !== 1'b1 || bus.stall !== 1'b0 || bus.pcsource !== 2'b00 || bus.discard !== 1'b1) begin
            n_fail++;
            $display("FAIL br_squash1: flush=%b stall=%b pcsource=%b discard=%b expected 1 0 00 1",
                     bus.flush, bus.stall, bus.pcsource, bus.discard);
        end
        tick();
        n_tests++;
        if (bus.flush !== 1'b1) begin
            n_fail++;
            $display("FAIL br_squash2: flush got %b expected 1", bus.flush);
        end
        tick();
        n_tests++;
        if (bus.flush !== 1'b0 || bus.stall !== 1'b0 || bus.proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL br_back_run: flush=%b stall=%b proto_err=%b expected 0 0 0",
                     bus.flush, bus.stall, bus.proto_err);
        end
        // not-taken branch
        bus.id_valid     = 1'b1;
        bus.id_is_branch = 1'b1;
        tick();
        clear_inputs();
        bus.br_resolve = 1'b1;
        #1;
        n_tests++;
        if (bus.pcsource !== 2'b00 || bus.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL br_not_taken: pcsource=%b stall=%b expected 00 1", bus.pcsource, bus.stall);
        end
        tick();
        clear_inputs();
        #1;
        n_tests++;
        if (bus.flush !== 1'b0 || bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL br_nt_run: flush=%b stall=%b expected 0 0", bus.flush, bus.stall);
        end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        bus.id_valid     = 1'b1;
        bus.id_is_branch = 1'b1;
        tick();
        bus.id_is_branch = 1'b0;
        bus.id_is_jump   = 1'b1;
        bus.br_resolve   = 1'b1;
        bus.br_taken     = 1'b1;
        #1;
        n_tests++;
        if (bus.pcsource !== 2'b01) begin
            n_fail++;
            $display("FAIL resolve_vs_jump: pcsource got %b expected 01", bus.pcsource);
        end
        tick();
        bus.br_resolve = 1'b0;
        bus.br_taken   = 1'b0;
        #1;
        n_tests++;
        if (bus.pcsource !== 2'b00 || bus.flush !== 1'b1) begin
            n_fail++;
            $display("FAIL squash_ignores_jump: pcsource=%b flush=%b expected 00 1", bus.pcsource, bus.flush);
        end
        tick();
        clear_inputs();
        tick();
        n_tests++;
        if (bus.flush !== 1'b0 || bus.proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_run: flush=%b proto_err=%b expected 0 0", bus.flush, bus.proto_err);
        end
    endtask

    task automatic test_jump_and_proto();
        clear_inputs();
        bus.id_valid   = 1'b1;
        bus.id_is_jump = 1'b1;
        #1;
        n_tests++;
        if (bus.pcsource !== 2'b10 || bus.flush !== 1'b0 || bus.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL jump_issue: pcsource=%b flush=%b stall=%b expected 10 0 0",
                     bus.pcsource, bus.flush, bus.stall);
        end
        tick();
        #1;
        n_tests++;
        if (bus.flush !== 1'b1 || bus.pcsource !== 2'b00) begin
            n_fail++;
            $display("FAIL jump_squash: flush=%b pcsource=%b expected 1 00", bus.flush, bus.pcsource);
        end
        clear_inputs();
        tick();
        n_tests++;
        if (bus.flush !== 1'b0) begin
            n_fail++;
            $display("FAIL jump_penalty_len: flush got %b expected 0", bus.flush);
        end
        bus.br_resolve = 1'b1;
        #1;
        n_tests++;
        if (bus.proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL proto_not_yet: proto_err got %b expected 0", bus.proto_err);
        end
        tick();
        bus.br_resolve = 1'b0;
        #1;
        n_tests++;
        if (bus.proto_err !== 1'b1 || bus.stall !== 1'b0 || bus.flush !== 1'b0) begin
            n_fail++;
            $display("FAIL proto_set: proto_err=%b stall=%b flush=%b expected 1 0 0",
                     bus.proto_err, bus.stall, bus.flush);
        end
        tick();
        tick();
        n_tests++;
        if (bus.proto_err !== 1'b1) begin
            n_fail++;
            $display("FAIL proto_sticky: proto_err got %b expected 1", bus.proto_err);
        end
    endtask

    task automatic test_reset_mid_squash();
        clear_inputs();
        bus.id_valid     = 1'b1;
        bus.id_is_branch = 1'b1;
        tick();
        clear_inputs();
        bus.br_resolve = 1'b1;
        bus.br_taken   = 1'b1;
        tick();
        clear_inputs();
        #1;
        n_tests++;
        if (bus.flush !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_squash: flush got %b expected 1", bus.flush);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.flush !== 1'b0 || bus.stall !== 1'b0 || bus.proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: flush=%b stall=%b proto_err=%b expected 0 0 0",
                     bus.flush, bus.stall, bus.proto_err);
        end
        tick();
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.flush !== 1'b0 || bus.stall !== 1'b0 || bus.proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: flush=%b stall=%b proto_err=%b expected 0 0 0",
                     bus.flush, bus.stall, bus.proto_err);
        end
        bus.id_valid     = 1'b1;
        bus.id_is_branch = 1'b1;
        tick();
        clear_inputs();
        #1;
        n_tests++;
        if (bus.stall !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_run: stall got %b expected 1 (branch issued from RUN)", bus.stall);
        end
        bus.br_resolve = 1'b1;
        tick();
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_r0_guard();
        test_load_use();
        test_branch();
        test_back_to_back();
        test_jump_and_proto();
        test_reset_mid_squash();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
